// File: rtl/col_norm_sq.sv
// Streaming column energy sum(re^2+im^2): square stage then accumulate stage; result one cycle after last beat.
// in_ready_o drops from last beat until the result is taken, so a held result stalls the input side.
module col_norm_sq #(
    parameter int DATA_W = 27,
    parameter int N_ELEM = 4,
    parameter int OUT_W  = 56
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [DATA_W-1:0] in_re_i,
    input  logic signed [DATA_W-1:0] in_im_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [OUT_W-1:0]         out_norm_sq_o
);

    // re^2+im^2 reaches 2^(2*DATA_W-1) for two most-negative parts, so the product keeps 2*DATA_W bits.
    localparam int P_W   = 2 * DATA_W;
    localparam int CNT_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [P_W-1:0]    p_q;
    logic              p_vld_q;
    logic              p_first_q;
    logic              p_last_q;
    logic [OUT_W-1:0]  acc_q;
    logic [OUT_W-1:0]  norm_q;
    logic              out_vld_q;

    logic signed [P_W-1:0] re_x;
    logic signed [P_W-1:0] im_x;
    logic signed [P_W-1:0] sq_re;
    logic signed [P_W-1:0] sq_im;
    logic [P_W-1:0]        p_d;
    logic [OUT_W-1:0]      acc_d;
    logic                  accept;
    logic                  last_beat;

    assign in_ready_o    = (state_q == ACC);
    assign out_valid_o   = out_vld_q;
    assign out_norm_sq_o = norm_q;

    assign accept    = in_valid_i && in_ready_o;
    assign last_beat = (cnt_q == CNT_W'(N_ELEM - 1));

    always_comb begin
        re_x  = P_W'(in_re_i);
        im_x  = P_W'(in_im_i);
        sq_re = re_x * re_x;
        sq_im = im_x * im_x;
        p_d   = $unsigned(sq_re) + $unsigned(sq_im);
        acc_d = p_first_q ? OUT_W'(p_q) : (acc_q + OUT_W'(p_q));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ACC;
            cnt_q     <= '0;
            p_q       <= '0;
            p_vld_q   <= 1'b0;
            p_first_q <= 1'b0;
            p_last_q  <= 1'b0;
            acc_q     <= '0;
            norm_q    <= '0;
            out_vld_q <= 1'b0;
        end else if (clr_i) begin
            state_q   <= ACC;
            cnt_q     <= '0;
            p_vld_q   <= 1'b0;
            acc_q     <= '0;
            norm_q    <= '0;
            out_vld_q <= 1'b0;
        end else begin
            p_vld_q <= accept;
            if (accept) begin
                p_q       <= p_d;
                p_first_q <= (cnt_q == '0);
                p_last_q  <= last_beat;
                if (last_beat) begin
                    cnt_q   <= '0;
                    state_q <= DRAIN;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (p_vld_q) begin
                acc_q <= acc_d;
                if (p_last_q) begin
                    norm_q    <= acc_d;
                    out_vld_q <= 1'b1;
                    state_q   <= HOLD;
                end
            end
            if (state_q == HOLD && out_ready_i) begin
                out_vld_q <= 1'b0;
                state_q   <= ACC;
            end
        end
    end

endmodule

// File: tb/tb_col_norm_sq.sv
// Scoreboarded bench for col_norm_sq: directed columns plus randomized columns with gaps and backpressure.
module tb_col_norm_sq;

    localparam int DATA_W = 27;
    localparam int N_ELEM = 4;
    localparam int OUT_W  = 56;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     clr = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_re = '0;
    logic signed [DATA_W-1:0] in_im = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [OUT_W-1:0]         out_norm_sq;

    logic [OUT_W-1:0] exp_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    longint           m_acc = 0;
    int               m_cnt = 0;
    bit               push_en = 1'b1;
    bit               rand_rdy = 1'b0;

    always #5 clk = ~clk;

    col_norm_sq #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .OUT_W(OUT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clr_i         (clr),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_re_i       (in_re),
        .in_im_i       (in_im),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_norm_sq_o (out_norm_sq)
    );

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: column energy is the plain arithmetic sum of squares of accepted beats.
    task automatic model_accept(input longint re, input longint im);
        m_acc += re * re + im * im;
        m_cnt++;
        if (m_cnt == N_ELEM) begin
            if (push_en) exp_q.push_back(OUT_W'(m_acc));
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_beat(input longint re, input longint im);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_re    = DATA_W'(re);
        in_im    = DATA_W'(im);
        for (int k = 0; k < 300 && !done; k++) begin
            if (in_ready) begin
                done = 1'b1;
                model_accept(re, im);
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("beat_accept_timeout", 0, 1);
    endtask

    task automatic send_col(input longint re, input longint im);
        for (int i = 0; i < N_ELEM; i++) send_beat(re, im);
    endtask

    function automatic longint rnd_comp();
        logic signed [DATA_W-1:0] v;
        int sel;
        sel = $urandom_range(0, 7);
        v   = DATA_W'($urandom);
        if (sel == 0) return -(longint'(1) <<< (DATA_W - 1));
        if (sel == 1) return (longint'(1) <<< (DATA_W - 1)) - 1;
        return longint'(v);
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && clr === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got %0h, expected no result", out_norm_sq);
            end else begin
                check("scoreboard", out_norm_sq, exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, with in_valid held high to show it is ignored
        in_valid = 1'b1;
        in_re    = 27'sd7;
        in_im    = 27'sd7;
        #1 rst = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_norm", out_norm_sq, 0);
        check("reset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_out_valid", out_valid, 0);
        check("reset_hold_in_ready", in_ready, 1);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();

        // column (3,4),(0,0),(1,-1),(-2,0): latency and ready behaviour
        out_ready = 1'b1;
        send_beat(3, 4);
        send_beat(0, 0);
        send_beat(1, -1);
        send_beat(-2, 0);
        check("drain_in_ready", in_ready, 0);
        check("drain_out_valid", out_valid, 0);
        tick();
        check("latency_out_valid", out_valid, 1);
        check("latency_norm", out_norm_sq, 31);
        check("hold_in_ready", in_ready, 0);
        tick();
        check("after_hs_in_ready", in_ready, 1);
        idle(2);

        // extreme negative inputs: 2^55 without overflow
        send_col(-(longint'(1) <<< 26), -(longint'(1) <<< 26));
        idle(4);

        // backpressure: result held for 10 cycles
        out_ready = 1'b0;
        send_beat(3, 4);
        send_beat(0, 0);
        send_beat(1, -1);
        send_beat(-2, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_norm", out_norm_sq, 31);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_norm_kept", out_norm_sq, 31);
        send_col(1, 1);
        idle(4);

        // in_valid pattern 1,0,0,1,0,1,1
        send_beat(3, 4);
        idle(2);
        send_beat(0, 0);
        idle(1);
        send_beat(1, -1);
        send_beat(-2, 0);
        idle(4);

        // clr aborts a partial column; the beat presented with clr is dropped
        send_beat(5, 5);
        send_beat(5, 5);
        in_valid = 1'b1;
        in_re    = 27'sd9;
        in_im    = 27'sd9;
        clr      = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        m_acc    = 0;
        m_cnt    = 0;
        check("clr_out_valid", out_valid, 0);
        check("clr_in_ready", in_ready, 1);
        send_col(1, 0);
        idle(4);

        // clr coinciding with an output handshake: clr wins and zeroes the result
        push_en   = 1'b0;
        out_ready = 1'b0;
        send_col(2, 0);
        tick();
        check("clrhs_pre_valid", out_valid, 1);
        check("clrhs_pre_norm", out_norm_sq, 16);
        out_ready = 1'b1;
        clr       = 1'b1;
        tick();
        clr = 1'b0;
        check("clrhs_out_valid", out_valid, 0);
        check("clrhs_norm", out_norm_sq, 0);
        check("clrhs_in_ready", in_ready, 1);

        // async reset while holding a result
        out_ready = 1'b0;
        send_col(1, 0);
        tick();
        check("rsthold_pre_valid", out_valid, 1);
        check("rsthold_pre_norm", out_norm_sq, 4);
        #2 rst = 1'b1;
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_norm", out_norm_sq, 0);
        check("rst_async_in_ready", in_ready, 1);
        m_acc = 0;
        m_cnt = 0;
        tick();
        rst     = 1'b0;
        push_en = 1'b1;
        tick();

        // randomized columns with input gaps and random backpressure
        rand_rdy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            for (int b = 0; b < N_ELEM; b++) begin
                send_beat(rnd_comp(), rnd_comp());
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
        idle(2);
        check("scoreboard_drained", OUT_W'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
